// File: rtl/rom_loader_if.sv
// Byte-stream handshake between an image source and the ROM loader.
// The source drives data/valid; the loader answers with ready.
interface rom_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/rom_loader.sv
// Instruction-memory stage: loads a framed, XOR-checked image, then serves instructions.
// Optional macro ROM_LOADER_RELOAD_EN adds a reload input to restart loading from RUN/ERROR.
module rom_loader #(
  parameter int DEPTH  = 32768,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  rom_loader_if.slave       rx,
`ifdef ROM_LOADER_RELOAD_EN
  input  logic              reload,
`endif
  input  logic [ADDR_W-1:0] pc,
  output logic [15:0]       instruction,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam logic [2:0] S_HDR_HI  = 3'd0;
  localparam logic [2:0] S_HDR_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  logic [2:0]  state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] wl_q, wl_d;
  logic [7:0]  csum_q, csum_d;
  logic        cpu_reset_q, load_done_q, load_err_q;

  logic        accept;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] n_hdr;
  logic [16:0] pc_ext;

  logic [15:0] store [DEPTH];

  assign rx.rx_ready = (state_q != S_RUN) && (state_q != S_ERROR);
  assign accept      = rx.rx_valid && rx.rx_ready;
  assign n_hdr       = {n_q[15:8], rx.rx_data};
  assign wdata       = {hi_q, rx.rx_data};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    n_d     = n_q;
    hi_d    = hi_q;
    wl_d    = wl_q;
    csum_d  = csum_q;
    we      = 1'b0;

    if (accept) begin
      case (state_q)
        S_HDR_HI: begin
          n_d[15:8] = rx.rx_data;
          csum_d    = csum_q ^ rx.rx_data;
          state_d   = S_HDR_LO;
        end
        S_HDR_LO: begin
          n_d    = n_hdr;
          csum_d = csum_q ^ rx.rx_data;
          if ({1'b0, n_hdr} > DEPTH_LIM) state_d = S_ERROR;
          else if (n_hdr == 16'd0)       state_d = S_CHECK;
          else                           state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = rx.rx_data;
          csum_d  = csum_q ^ rx.rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we      = 1'b1;
          wl_d    = wl_q + 16'd1;
          csum_d  = csum_q ^ rx.rx_data;
          state_d = (wl_d == n_q) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          state_d = (rx.rx_data == csum_q) ? S_RUN : S_ERROR;
        end
        default: ;
      endcase
    end

`ifdef ROM_LOADER_RELOAD_EN
    if (reload && (state_q == S_RUN || state_q == S_ERROR)) begin
      state_d = S_HDR_HI;
      n_d     = 16'd0;
      wl_d    = 16'd0;
      csum_d  = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= S_HDR_HI;
      n_q         <= 16'd0;
      hi_q        <= 8'd0;
      wl_q        <= 16'd0;
      csum_q      <= 8'd0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      hi_q        <= hi_d;
      wl_q        <= wl_d;
      csum_q      <= csum_d;
      cpu_reset_q <= (state_d != S_RUN);
      load_done_q <= (state_d == S_RUN);
      load_err_q  <= (state_d == S_ERROR);
    end
  end

  // NOTE: the program store has no reset; clearing it would need a write per word.
  always_ff @(posedge clk) begin
    if (we && reset) store[wl_q[ADDR_W-1:0]] <= wdata;
  end

  assign pc_ext = 17'(pc);

  // Words beyond the loaded count read as zero so stale contents stay unreachable.
  always_comb begin
    instruction = 16'h0000;
    if (state_q == S_RUN && pc_ext < {1'b0, n_q}) instruction = store[pc];
  end

  assign cpu_reset    = cpu_reset_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = wl_q;

endmodule
